hart_issue_sched: RTL and testbench

- Per-cycle hart scheduler for the multi-hart FMRT Mini Core. It picks which hart the IF stage fetches from and drives `issue_id` into the main controller.
- It parks harts that have a pending I-cache or D-cache miss, reported by the controller's `cache_miss`, `cm_hart_id` and `cm_addr` outputs.
- When the refill completes it wakes the parked hart with a one-cycle restart request carrying the saved PC.
- Selection is round-robin among ready harts. Inactive harts are never issued.

---
 rtl/hart_issue_sched_if.sv | 33 +++
 rtl/hart_issue_sched.sv | 139 +++++++++++++
 tb/tb_hart_issue_sched.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/hart_issue_sched_if.sv
// Bundle of signals between the main controller/IF stage and the hart issue scheduler.
// The controller side drives miss/refill reports; the scheduler drives issue and restart.
interface hart_issue_sched_if #(
  parameter int HART_NUM  = 4,
  parameter int HART_ID_W = 2,
  parameter int ADDR_W    = 32
);
  logic [HART_NUM-1:0]  hart_active;
  logic                 issue_stall;
  logic                 cache_miss;
  logic [HART_ID_W-1:0] cm_hart_id;
  logic [ADDR_W-1:0]    cm_addr;
  logic                 refill_done;
  logic [HART_ID_W-1:0] refill_hart_id;
  logic [HART_ID_W-1:0] issue_id;
  logic                 issue_valid;
  logic                 restart_en;
  logic [HART_ID_W-1:0] restart_id;
  logic [ADDR_W-1:0]    restart_pc;
  logic [HART_NUM-1:0]  hart_waiting;

  modport master (
    output hart_active, issue_stall, cache_miss, cm_hart_id, cm_addr,
           refill_done, refill_hart_id,
    input  issue_id, issue_valid, restart_en, restart_id, restart_pc, hart_waiting
  );

  modport slave (
    input  hart_active, issue_stall, cache_miss, cm_hart_id, cm_addr,
           refill_done, refill_hart_id,
    output issue_id, issue_valid, restart_en, restart_id, restart_pc, hart_waiting
  );
endinterface

// File: rtl/hart_issue_sched.sv
// Per-cycle hart scheduler: parks harts on cache misses, restarts them after refill,
// and picks the fetch hart round-robin among READY harts.
module hart_issue_sched #(
  parameter int HART_NUM  = 4,
  parameter int HART_ID_W = 2,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset_,
  hart_issue_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READY, WAIT, RESUME} hart_state_e;

  hart_state_e          state_q    [HART_NUM];
  hart_state_e          state_d    [HART_NUM];
  logic [ADDR_W-1:0]    saved_pc_q [HART_NUM];
  logic [ADDR_W-1:0]    saved_pc_d [HART_NUM];
  logic [HART_NUM-1:0]  next_ready;
  logic [HART_NUM-1:0]  waiting;

  logic [HART_ID_W-1:0] ptr_q, ptr_d;
  logic [HART_ID_W-1:0] issue_id_q, issue_id_d;
  logic                 issue_valid_q, issue_valid_d;
  logic                 restart_en_q, restart_en_d;
  logic [HART_ID_W-1:0] restart_id_q, restart_id_d;
  logic [ADDR_W-1:0]    restart_pc_q, restart_pc_d;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin : hart_next
    logic miss_hit;
    logic refill_hit;
    miss_hit     = 1'b0;
    refill_hit   = 1'b0;
    next_ready   = '0;
    restart_en_d = 1'b0;
    restart_id_d = restart_id_q;
    restart_pc_d = restart_pc_q;
    for (int i = 0; i < HART_NUM; i++) begin
      miss_hit      = bus.cache_miss  && (bus.cm_hart_id     == HART_ID_W'(i));
      refill_hit    = bus.refill_done && (bus.refill_hart_id == HART_ID_W'(i));
      state_d[i]    = state_q[i];
      saved_pc_d[i] = saved_pc_q[i];
      // Deactivation beats every other event and drops any parked miss.
      if (!bus.hart_active[i]) begin
        state_d[i]    = IDLE;
        saved_pc_d[i] = '0;
      end else begin
        case (state_q[i])
          IDLE:  state_d[i] = READY;
          READY: begin
            if (miss_hit) begin
              state_d[i]    = WAIT;
              saved_pc_d[i] = bus.cm_addr;
            end
          end
          WAIT: begin
            if (miss_hit) begin
              saved_pc_d[i] = bus.cm_addr;
            end else if (refill_hit) begin
              state_d[i]   = RESUME;
              restart_en_d = 1'b1;
              restart_id_d = HART_ID_W'(i);
              restart_pc_d = saved_pc_q[i];
            end
          end
          RESUME: begin
            state_d[i] = READY;
            if (miss_hit) saved_pc_d[i] = bus.cm_addr;
          end
          default: state_d[i] = IDLE;
        endcase
      end
      next_ready[i] = (state_d[i] == READY);
    end
  end

  always_comb begin : issue_select
    logic [HART_ID_W-1:0] cand;
    cand          = '0;
    issue_id_d    = issue_id_q;
    ptr_d         = ptr_q;
    issue_valid_d = 1'b0;
    if (bus.issue_stall && next_ready[issue_id_q]) begin
      issue_valid_d = 1'b1;
    end else begin
      // Scan from the farthest offset down so the nearest candidate after ptr wins.
      for (int k = HART_NUM; k >= 1; k--) begin
        cand = ptr_q + HART_ID_W'(k);
        if (next_ready[cand]) begin
          issue_id_d    = cand;
          ptr_d         = cand;
          issue_valid_d = 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      // NOTE: the saved-PC array is reset explicitly; it is a small register file, not a RAM.
      for (int i = 0; i < HART_NUM; i++) begin
        state_q[i]    <= IDLE;
        saved_pc_q[i] <= '0;
      end
      ptr_q         <= HART_ID_W'(HART_NUM - 1);
      issue_id_q    <= '0;
      issue_valid_q <= 1'b0;
      restart_en_q  <= 1'b0;
      restart_id_q  <= '0;
      restart_pc_q  <= '0;
    end else begin
      for (int i = 0; i < HART_NUM; i++) begin
        state_q[i]    <= state_d[i];
        saved_pc_q[i] <= saved_pc_d[i];
      end
      ptr_q         <= ptr_d;
      issue_id_q    <= issue_id_d;
      issue_valid_q <= issue_valid_d;
      restart_en_q  <= restart_en_d;
      restart_id_q  <= restart_id_d;
      restart_pc_q  <= restart_pc_d;
    end
  end

  always_comb begin
    waiting = '0;
    for (int i = 0; i < HART_NUM; i++) waiting[i] = (state_q[i] == WAIT);
  end

  assign bus.issue_id     = issue_id_q;
  assign bus.issue_valid  = issue_valid_q;
  assign bus.restart_en   = restart_en_q;
  assign bus.restart_id   = restart_id_q;
  assign bus.restart_pc   = restart_pc_q;
  assign bus.hart_waiting = waiting;

endmodule

// File: tb/tb_hart_issue_sched.sv
// Self-checking bench for hart_issue_sched: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the scheduling rules.
module tb_hart_issue_sched;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int AW = 32;

  localparam int M_IDLE = 0, M_READY = 1, M_WAIT = 2, M_RESUME = 3;

  logic clk;
  logic reset_;
  int   n_vec;
  int   n_err;

  // Reference model state
  int          m_st  [N];
  logic [31:0] m_pc  [N];
  int          m_ptr, m_iid;
  bit          m_ival, m_ren;
  int          m_rid;
  logic [31:0] m_rpc;

  hart_issue_sched_if #(.HART_NUM(N), .HART_ID_W(IW), .ADDR_W(AW)) bus ();

  hart_issue_sched #(.HART_NUM(N), .HART_ID_W(IW), .ADDR_W(AW)) dut (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs as they stand at the edge.
  task automatic model_step();
    int          nst [N];
    logic [31:0] npc [N];
    bit          miss, rf, found;
    int          h;
    if (!reset_) begin
      for (int i = 0; i < N; i++) begin m_st[i] = M_IDLE; m_pc[i] = 0; end
      m_ptr = N - 1; m_iid = 0; m_ival = 0; m_ren = 0; m_rid = 0; m_rpc = 0;
      return;
    end
    m_ren = 0;
    for (int i = 0; i < N; i++) begin
      miss   = bus.cache_miss  && (int'(bus.cm_hart_id) == i);
      rf     = bus.refill_done && (int'(bus.refill_hart_id) == i);
      nst[i] = m_st[i];
      npc[i] = m_pc[i];
      if (!bus.hart_active[i]) begin
        nst[i] = M_IDLE; npc[i] = 0;
      end else begin
        if (miss && m_st[i] != M_IDLE) npc[i] = bus.cm_addr;
        if (m_st[i] == M_IDLE) nst[i] = M_READY;
        else if (m_st[i] == M_READY && miss) nst[i] = M_WAIT;
        else if (m_st[i] == M_WAIT && rf && !miss) begin
          nst[i] = M_RESUME; m_ren = 1; m_rid = i; m_rpc = m_pc[i];
        end else if (m_st[i] == M_RESUME) nst[i] = M_READY;
      end
    end
    if (bus.issue_stall && nst[m_iid] == M_READY) begin
      m_ival = 1;
    end else begin
      found = 0;
      for (int k = 1; k <= N && !found; k++) begin
        h = (m_ptr + k) % N;
        if (nst[h] == M_READY) begin found = 1; m_iid = h; m_ptr = h; end
      end
      m_ival = found;
    end
    for (int i = 0; i < N; i++) begin m_st[i] = nst[i]; m_pc[i] = npc[i]; end
  endtask

  task automatic step();
    logic [N-1:0] w;
    @(posedge clk);
    model_step();
    #1;
    w = '0;
    for (int i = 0; i < N; i++) w[i] = (m_st[i] == M_WAIT);
    check("issue_valid", 64'(bus.issue_valid), 64'(m_ival));
    check("issue_id", 64'(bus.issue_id), 64'(m_iid));
    check("restart_en", 64'(bus.restart_en), 64'(m_ren));
    if (m_ren) begin
      check("restart_id", 64'(bus.restart_id), 64'(m_rid));
      check("restart_pc", 64'(bus.restart_pc), 64'(m_rpc));
    end
    check("hart_waiting", 64'(bus.hart_waiting), 64'(w));
  endtask

  task automatic quiet();
    bus.issue_stall = 0; bus.cache_miss = 0; bus.refill_done = 0;
    bus.cm_hart_id = '0; bus.cm_addr = '0; bus.refill_hart_id = '0;
  endtask

  task automatic miss(input int h, input logic [31:0] a);
    bus.cache_miss = 1; bus.cm_hart_id = IW'(h); bus.cm_addr = a;
  endtask

  task automatic refill(input int h);
    bus.refill_done = 1; bus.refill_hart_id = IW'(h);
  endtask

  initial begin
    int h;
    n_vec = 0; n_err = 0;
    quiet();
    bus.hart_active = 4'b1111;

    // 1. Reset, then plain round-robin 0,1,2,3,0...
    reset_ = 0;
    #1; step();
    check("rst_issue_valid", 64'(bus.issue_valid), 64'd0);
    check("rst_restart_pc", 64'(bus.restart_pc), 64'd0);
    reset_ = 1;
    for (int c = 0; c < 6; c++) begin
      step();
      check("rr_seq", 64'(bus.issue_id), 64'(c % 4));
    end

    // 2. Miss on hart 1 with hart 2 disabled; rotation 0,3; refill 10 cycles later.
    bus.hart_active = 4'b1011;
    step(); step();
    miss(1, 32'h100); step(); quiet();
    check("miss_waiting", 64'(bus.hart_waiting), 64'b0010);
    for (int c = 0; c < 9; c++) begin
      step();
      check("rot_no_h1", 64'(bus.issue_id == 1), 64'd0);
    end
    refill(1); step(); quiet();
    check("rf_en", 64'(bus.restart_en), 64'd1);
    check("rf_id", 64'(bus.restart_id), 64'd1);
    check("rf_pc", 64'(bus.restart_pc), 64'h100);
    for (int c = 0; c < 4; c++) step();

    // 3. Miss and refill on hart 2 in the same cycle: miss wins.
    bus.hart_active = 4'b1111;
    step(); step();
    miss(2, 32'h180); step(); quiet();
    miss(2, 32'h200); refill(2); step(); quiet();
    check("sim_wait", 64'(bus.hart_waiting[2]), 64'd1);
    check("sim_no_rst", 64'(bus.restart_en), 64'd0);
    refill(2); step(); quiet();
    check("sim_pc", 64'(bus.restart_pc), 64'h200);
    step(); step();

    // 4. Stall holds hart 2; deactivating hart 2 forces a move to 3.
    for (int c = 0; c < 8 && m_iid != 2; c++) step();
    bus.issue_stall = 1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("stall_hold", 64'(bus.issue_id), 64'd2);
    end
    bus.hart_active = 4'b1011;
    step();
    check("stall_deact", 64'(bus.issue_id), 64'd3);
    quiet();

    // 5. Only hart 0 active and it misses: nothing to issue, id holds.
    bus.hart_active = 4'b0001;
    step(); step();
    miss(0, 32'h40); step(); quiet();
    check("park_valid", 64'(bus.issue_valid), 64'd0);
    check("park_id", 64'(bus.issue_id), 64'd0);
    refill(1); step(); quiet();
    check("park_rf1", 64'(bus.restart_en), 64'd0);
    refill(0); step(); quiet();
    step();

    // 6. Reset while hart 3 is in WAIT; its later refill is ignored.
    bus.hart_active = 4'b1111;
    step(); step();
    miss(3, 32'h300); step(); quiet();
    check("w3", 64'(bus.hart_waiting), 64'b1000);
    reset_ = 0; step(); reset_ = 1;
    refill(3); step(); quiet();
    check("rst_rf_en", 64'(bus.restart_en), 64'd0);
    check("rst_rf_wait", 64'(bus.hart_waiting), 64'd0);

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      quiet();
      reset_ = ($urandom_range(63) != 0);
      for (int i = 0; i < N; i++) bus.hart_active[i] = ($urandom_range(15) != 0);
      bus.issue_stall = ($urandom_range(3) == 0);
      if ($urandom_range(2) == 0) begin
        h = $urandom_range(N - 1);
        if (m_st[h] != M_RESUME) miss(h, $urandom);
      end
      if ($urandom_range(2) == 0) refill($urandom_range(N - 1));
      step();
    end
    quiet();
    reset_ = 1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
